// File: rtl/ifm_ctrl_pkg.sv
// ifm_ctrl_pkg: shared definitions for the IFM tile load sequencer.
//   state_t     - sequencer state encoding
//   burst_bytes - byte span of one fixed-length engine burst
package ifm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  function automatic int unsigned burst_bytes(input int unsigned len,
                                              input int unsigned data_w);
    return (len * data_w) / 8;
  endfunction

endpackage

// File: rtl/ifm_load_ctrl_if.sv
// ifm_load_ctrl_if: descriptor handshake from the layer controller plus the
// start/base_addr/done handshake towards the IFM burst-read engine.
//   master : environment side (drives descriptor and rd_done)
//   slave  : sequencer side (ifm_load_ctrl)
interface ifm_load_ctrl_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int CNT_W      = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [AXI_ADDR_W-1:0] cfg_base_addr;
  logic [CNT_W-1:0]      cfg_rows;
  logic [CNT_W-1:0]      cfg_bursts_per_row;
  logic [AXI_ADDR_W-1:0] cfg_row_stride;

  logic                  rd_start;
  logic [AXI_ADDR_W-1:0] rd_base_addr;
  logic                  rd_done;
  logic [CNT_W-1:0]      rd_burst_idx;

  modport master (
    output cfg_valid, cfg_base_addr, cfg_rows, cfg_bursts_per_row, cfg_row_stride,
    output rd_done,
    input  cfg_ready, rd_start, rd_base_addr, rd_burst_idx
  );

  modport slave (
    input  cfg_valid, cfg_base_addr, cfg_rows, cfg_bursts_per_row, cfg_row_stride,
    input  rd_done,
    output cfg_ready, rd_start, rd_base_addr, rd_burst_idx
  );
endinterface

// File: rtl/ifm_addr_gen.sv
// ifm_addr_gen: address / counter datapath for the IFM tile walk.
//   load           - capture descriptor, point at row 0 burst 0
//   step           - advance to the next burst (row-major)
//   base/rows/bursts_per_row/row_stride - descriptor fields
//   addr           - current burst byte address (registered)
//   burst_idx      - linear burst index within the tile (registered)
//   last           - current burst is the final burst of the tile
module ifm_addr_gen #(
  parameter int                    AXI_ADDR_W  = 32,
  parameter int                    CNT_W       = 16,
  parameter logic [AXI_ADDR_W-1:0] BURST_BYTES = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [AXI_ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]      rows,
  input  logic [CNT_W-1:0]      bursts_per_row,
  input  logic [AXI_ADDR_W-1:0] row_stride,
  output logic [AXI_ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]      burst_idx,
  output logic                  last
);

  logic [AXI_ADDR_W-1:0] row_base, stride_q;
  logic [CNT_W-1:0]      rows_q, bpr_q, row, burst;
  logic [AXI_ADDR_W-1:0] row_base_nxt;
  logic                  row_end;

  // Next row start; address arithmetic wraps modulo 2^AXI_ADDR_W.
  assign row_base_nxt = row_base + stride_q;
  assign row_end      = (burst == bpr_q - CNT_W'(1));
  assign last         = row_end && (row == rows_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base  <= '0;
      stride_q  <= '0;
      rows_q    <= '0;
      bpr_q     <= '0;
      row       <= '0;
      burst     <= '0;
      addr      <= '0;
      burst_idx <= '0;
    end else if (load) begin
      row_base  <= base;
      stride_q  <= row_stride;
      rows_q    <= rows;
      bpr_q     <= bursts_per_row;
      row       <= '0;
      burst     <= '0;
      addr      <= base;
      burst_idx <= '0;
    end else if (step) begin
      burst_idx <= burst_idx + CNT_W'(1);
      if (row_end) begin
        burst    <= '0;
        row      <= row + CNT_W'(1);
        row_base <= row_base_nxt;
        addr     <= row_base_nxt;
      end else begin
        burst <= burst + CNT_W'(1);
        addr  <= addr + BURST_BYTES;
      end
    end
  end

endmodule

// File: rtl/ifm_load_ctrl.sv
// ifm_load_ctrl: sequences fixed-length bursts on the IFM burst-read engine
// to load one input-feature-map tile described by a single descriptor.
//   clk, rst_n     - clock, asynchronous active-low reset
//   bus (slave)    - descriptor handshake (cfg_*) and engine handshake
//                    (rd_start, rd_base_addr, rd_done, rd_burst_idx)
//   busy           - sequencer not idle
//   tile_done      - one-cycle pulse when the tile has been loaded
//   err_timeout    - sticky watchdog flag
// Optional build macro IFM_LOAD_TIMEOUT_EN: adds a WAIT-state watchdog of
// TIMEOUT_CYC cycles; without it err_timeout is constant 0.
module ifm_load_ctrl
  import ifm_ctrl_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_DATA_W  = 128,
  parameter int BURST_LEN   = 128,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  ifm_load_ctrl_if.slave   bus,
  output logic             busy,
  output logic             tile_done,
  output logic             err_timeout
);

  localparam logic [AXI_ADDR_W-1:0] BURST_INC =
    AXI_ADDR_W'(burst_bytes(BURST_LEN, AXI_DATA_W));

  // Elaboration-time sanity check on the watchdog limit.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("ifm_load_ctrl: TIMEOUT_CYC must be >= 1");
  end

  state_t state, state_nxt;
  logic   accept, cfg_empty, last, tmo_hit;

  assign accept    = (state == S_IDLE) && bus.cfg_valid;
  assign cfg_empty = (bus.cfg_rows == '0) || (bus.cfg_bursts_per_row == '0);

  ifm_addr_gen #(
    .AXI_ADDR_W (AXI_ADDR_W),
    .CNT_W      (CNT_W),
    .BURST_BYTES(BURST_INC)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (accept),
    .step          (state == S_NEXT),
    .base          (bus.cfg_base_addr),
    .rows          (bus.cfg_rows),
    .bursts_per_row(bus.cfg_bursts_per_row),
    .row_stride    (bus.cfg_row_stride),
    .addr          (bus.rd_base_addr),
    .burst_idx     (bus.rd_burst_idx),
    .last          (last)
  );

`ifdef IFM_LOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the TIMEOUT_CYC-th WAIT cycle; a same-cycle rd_done wins.
  assign tmo_hit = (state == S_WAIT) && !bus.rd_done &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_ISSUE)     tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (accept)       err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end
  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.cfg_valid) state_nxt = cfg_empty ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  begin
        if (bus.rd_done)  state_nxt = S_NEXT;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      // last reflects the burst just completed; counters step on this edge.
      S_NEXT:  state_nxt = last ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore-decoded outputs: no input-to-output combinational path.
  assign bus.cfg_ready = (state == S_IDLE);
  assign bus.rd_start  = (state == S_ISSUE);
  assign busy          = (state != S_IDLE);
  assign tile_done     = (state == S_DONE);

endmodule

// File: tb/tb_ifm_load_ctrl.sv
// tb_ifm_load_ctrl: scoreboard bench for ifm_load_ctrl. Expected burst
// addresses/indices are queued when a descriptor is driven and popped on
// every rd_start; an engine model answers rd_done 5 cycles after rd_start.
module tb_ifm_load_ctrl;

  localparam int          AW = 32;
  localparam int          CW = 16;
  localparam logic [31:0] BB = 32'd2048;   // 128 beats * 16 bytes

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifm_load_ctrl_if #(.AXI_ADDR_W(AW), .CNT_W(CW)) bus();
  logic busy, tile_done, err_timeout;

  ifm_load_ctrl #(
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (128),
    .BURST_LEN  (128),
    .CNT_W      (CW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .tile_done  (tile_done),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   start_hist[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   tile_cnt = 0, last_tile_cyc = 0;
  int   done_cyc = 0;
  bit   gap_armed = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Engine model
  logic eng_done = 1'b0, spur_done = 1'b0;
  bit   eng_en = 1;
  int   eng_cnt = 0;
  assign bus.rd_done = eng_done | spur_done;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!rst_n) eng_cnt = 0;
    else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done  = 1'b1;
        done_cyc  = cyc;
        gap_armed = 1;
      end
    end else if (bus.rd_start && eng_en) eng_cnt = 5;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.rd_start) begin
      start_hist.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_rd_start", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_base_addr", bus.rd_base_addr, e.addr);
        chk("rd_burst_idx", bus.rd_burst_idx, e.idx);
      end
      if (gap_armed) begin
        chk("done_to_start", cyc - done_cyc, 2);
        gap_armed = 0;
      end
    end
    if (rst_n && tile_done) begin
      tile_cnt++;
      last_tile_cyc = cyc;
      if (gap_armed) begin
        chk("done_to_tile", cyc - done_cyc, 2);
        gap_armed = 0;
      end
    end
  end

  task automatic send(input logic [31:0] base, input logic [15:0] rows,
                      input logic [15:0] bpr, input logic [31:0] stride,
                      output int acc);
    int          k;
    logic [31:0] a;
    logic [15:0] idx;
    k = 0;
    idx = '0;
    @(negedge clk);
    while (!bus.cfg_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cfg_ready_wait", bus.cfg_ready, 1);
    bus.cfg_valid          = 1'b1;
    bus.cfg_base_addr      = base;
    bus.cfg_rows           = rows;
    bus.cfg_bursts_per_row = bpr;
    bus.cfg_row_stride     = stride;
    acc = cyc;
    for (int r = 0; r < int'(rows); r++)
      for (int b = 0; b < int'(bpr); b++) begin
        a = base + stride * r + BB * b;
        exp_q.push_back('{a, idx});
        idx++;
      end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_tile(input string tag, input int n0, input int max);
    int k;
    k = 0;
    while (tile_cnt == n0 && k < max) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_tile_seen"}, (tile_cnt != n0), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cfg_ready"},   bus.cfg_ready, 1);
    chk({tag, "_rd_start"},    bus.rd_start, 0);
    chk({tag, "_rd_base"},     bus.rd_base_addr, 0);
    chk({tag, "_rd_idx"},      bus.rd_burst_idx, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_tile_done"},   tile_done, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL global_time_limit: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int acc, n0, s0, lat;
    bus.cfg_valid          = 1'b0;
    bus.cfg_base_addr      = '0;
    bus.cfg_rows           = '0;
    bus.cfg_bursts_per_row = '0;
    bus.cfg_row_stride     = '0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // Main tile: 2 rows x 2 bursts
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h1000_0000, 16'd2, 16'd2, 32'h0001_0000, acc);
    wait_tile("main", n0, 200);
    repeat (3) @(negedge clk);
    chk("main_tiles",     tile_cnt - n0, 1);
    chk("main_starts",    start_hist.size() - s0, 4);
    chk("main_first_lat", start_hist[s0] - acc, 1);
    chk("main_q_empty",   exp_q.size(), 0);
    chk("main_idle",      busy, 0);

    // Empty descriptors
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h0000_3000, 16'd0, 16'd4, 32'h100, acc);
    wait_tile("zrows", n0, 20);
    lat = last_tile_cyc - acc;
    chk("zrows_lat_ok", (lat >= 1 && lat <= 2), 1);
    repeat (2) @(negedge clk);
    chk("zrows_starts", start_hist.size() - s0, 0);

    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h0000_3000, 16'd3, 16'd0, 32'h100, acc);
    wait_tile("zbursts", n0, 20);
    lat = last_tile_cyc - acc;
    chk("zbursts_lat_ok", (lat >= 1 && lat <= 2), 1);
    repeat (2) @(negedge clk);
    chk("zbursts_starts", start_hist.size() - s0, 0);

    // Address wrap
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'hFFFF_F800, 16'd1, 16'd2, 32'h1000, acc);
    wait_tile("wrap", n0, 100);
    repeat (2) @(negedge clk);
    chk("wrap_starts",  start_hist.size() - s0, 2);
    chk("wrap_q_empty", exp_q.size(), 0);

    // Spurious rd_done while idle
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_busy",      busy, 0);
    chk("spur_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    chk("spur_busy2",     busy, 0);

    // cfg_valid while waiting on the engine; 3 rows x 1 burst
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h0000_2000, 16'd3, 16'd1, 32'h100, acc);
    @(negedge clk);
    bus.cfg_valid          = 1'b1;
    bus.cfg_base_addr      = 32'hDEAD_0000;
    bus.cfg_rows           = 16'd1;
    bus.cfg_bursts_per_row = 16'd1;
    for (int i = 0; i < 3; i++) begin
      chk("wait_cfg_ready", bus.cfg_ready, 0);
      chk("wait_busy",      busy, 1);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    wait_tile("cfgwait", n0, 200);
    repeat (3) @(negedge clk);
    chk("cfgwait_tiles",   tile_cnt - n0, 1);
    chk("cfgwait_starts",  start_hist.size() - s0, 3);
    chk("cfgwait_q_empty", exp_q.size(), 0);

    // Reset in WAIT, then restart
    send(32'h4000_0000, 16'd2, 16'd2, 32'h8000, acc);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    exp_q.delete();
    gap_armed = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h5000_0000, 16'd1, 16'd2, 32'h0, acc);
    wait_tile("restart", n0, 100);
    repeat (2) @(negedge clk);
    chk("restart_tiles",  tile_cnt - n0, 1);
    chk("restart_starts", start_hist.size() - s0, 2);
    chk("restart_lat",    start_hist[s0] - acc, 1);

`ifdef IFM_LOAD_TIMEOUT_EN
    // Engine silent: watchdog ends the tile 16 WAIT cycles after ISSUE
    eng_en = 0;
    n0 = tile_cnt; s0 = start_hist.size();
    send(32'h0000_6000, 16'd1, 16'd1, 32'h0, acc);
    wait_tile("tmo", n0, 100);
    @(negedge clk);
    chk("tmo_lat", last_tile_cyc - start_hist[s0], 17);
    chk("tmo_err", err_timeout, 1);
    eng_en = 1;
    n0 = tile_cnt;
    send(32'h0000_7000, 16'd1, 16'd1, 32'h0, acc);
    chk("tmo_err_clr", err_timeout, 0);
    wait_tile("tmo_after", n0, 100);
    @(negedge clk);
    chk("tmo_err_after", err_timeout, 0);
`else
    chk("err_tied_low", err_timeout, 0);
`endif

    chk("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
